// File: rtl/tx_pkg.sv
// Shared types and helpers for the TX PA ramp controller: FSM state encoding,
// the power-level clamp and the power-level-to-drive-word lookup.
package tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } state_e;

  localparam int unsigned LUT_STEP = 15;

  // Out-of-range requests saturate to the highest defined level.
  function automatic int unsigned clamp_level(input logic [4:0] level,
                                              input int unsigned num_levels);
    int unsigned lvl;
    lvl = 32'(level);
    return (lvl > num_levels - 1) ? num_levels - 1 : lvl;
  endfunction

  function automatic int unsigned power_lut(input int unsigned idx);
    return LUT_STEP * idx;
  endfunction

endpackage

// File: rtl/ramp_step_counter.sv
// Ramp timing: a step counter that advances ramp_idx up or down once every
// STEP_CYCLES cycles, saturating at 0 and at 2^RAMP_SHIFT.
module ramp_step_counter #(
  parameter int RAMP_SHIFT  = 3,
  parameter int STEP_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_all_i,
  input  logic                  clr_step_i,
  input  logic                  up_i,
  input  logic                  down_i,
  output logic [RAMP_SHIFT:0]   ramp_idx_o,
  output logic                  step_last_o
);

  localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [RAMP_SHIFT:0] IDX_MAX  = (RAMP_SHIFT + 1)'(1 << RAMP_SHIFT);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RAMP_SHIFT:0] idx_q, idx_d;

  assign step_last_o = (cnt_q == CNT_LAST);
  assign ramp_idx_o  = idx_q;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned and a latch is never inferred.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (clr_all_i) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (clr_step_i) begin
      cnt_d = '0;
    end else if (up_i || down_i) begin
      if (step_last_o) begin
        cnt_d = '0;
        if (up_i && idx_q != IDX_MAX) begin
          idx_d = idx_q + 1'b1;
        end else if (down_i && idx_q != '0) begin
          idx_d = idx_q - 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, matching hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/tx_pa_ramp_ctrl.sv
// PA power ramp controller: ramps the PA drive word up to a target level on
// tx_start, holds it for the burst, and ramps back down on tx_end.
module tx_pa_ramp_ctrl
  import tx_pkg::*;
#(
  parameter int CONTROL_WORD_WIDTH = 8,
  parameter int NUM_POWER_LEVELS   = 17,
  parameter int RAMP_SHIFT         = 3,
  parameter int STEP_CYCLES        = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_start,
  input  logic                          tx_end,
  input  logic [4:0]                    power_level,
  output logic [CONTROL_WORD_WIDTH-1:0] pa_ctrl_word,
  output logic                          pa_enable,
  output logic                          tx_ready,
  output logic                          ramp_busy,
  output logic                          start_err,
  output logic [1:0]                    state_dbg
);

  localparam int RAMP_STEPS = 1 << RAMP_SHIFT;
  localparam int IDX_W      = RAMP_SHIFT + 1;
  localparam int PROD_W     = CONTROL_WORD_WIDTH + RAMP_SHIFT + 1;
  localparam logic [IDX_W-1:0] IDX_TOP_M1 = IDX_W'(RAMP_STEPS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

  state_e                        state_q, state_d;
  logic [CONTROL_WORD_WIDTH-1:0] target_q, target_d;
  logic                          start_err_q, start_err_d;
  logic                          rst_q;
  logic                          clr_all, clr_step, cnt_up, cnt_down;
  logic [IDX_W-1:0]              ramp_idx;
  logic                          step_last;
  logic [PROD_W-1:0]             prod;

  ramp_step_counter #(
    .RAMP_SHIFT  (RAMP_SHIFT),
    .STEP_CYCLES (STEP_CYCLES)
  ) u_step_cnt (
    .clk         (clk),
    .rst         (rst),
    .clr_all_i   (clr_all),
    .clr_step_i  (clr_step),
    .up_i        (cnt_up),
    .down_i      (cnt_down),
    .ramp_idx_o  (ramp_idx),
    .step_last_o (step_last)
  );

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    clr_all     = 1'b0;
    clr_step    = 1'b0;
    cnt_up      = 1'b0;
    cnt_down    = 1'b0;
    start_err_d = tx_start && (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        // rst_q blocks a start request arriving in the cycle reset is released.
        if (tx_start && !tx_end && !rst_q) begin
          state_d  = ST_RAMP_UP;
          clr_all  = 1'b1;
          target_d = CONTROL_WORD_WIDTH'(power_lut(clamp_level(power_level, NUM_POWER_LEVELS)));
        end
      end
      ST_RAMP_UP: begin
        if (tx_end) begin
          state_d  = ST_RAMP_DOWN;
          clr_step = 1'b1;
        end else begin
          cnt_up = 1'b1;
          if (step_last && ramp_idx == IDX_TOP_M1) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (tx_end) begin
          state_d  = ST_RAMP_DOWN;
          clr_step = 1'b1;
        end
      end
      ST_RAMP_DOWN: begin
        if (ramp_idx == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_down = 1'b1;
          if (step_last && ramp_idx == IDX_ONE) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      target_q    <= '0;
      start_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      start_err_q <= start_err_d;
    end
  end

  always_ff @(posedge clk) begin
    rst_q <= rst;
  end

  // Product is one bit wider than needed for target * RAMP_STEPS, so it cannot wrap.
  assign prod         = PROD_W'(target_q) * PROD_W'(ramp_idx);
  assign pa_ctrl_word = CONTROL_WORD_WIDTH'(prod >> RAMP_SHIFT);
  assign pa_enable    = (state_q != ST_IDLE);
  assign tx_ready     = (state_q == ST_HOLD);
  assign ramp_busy    = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);
  assign start_err    = start_err_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_tx_pa_ramp_ctrl.sv
// Directed bench for tx_pa_ramp_ctrl at default parameters: ramp up/down,
// aborted ramp, clamping, rejected starts and mid-ramp reset.
module tb_tx_pa_ramp_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_start;
  logic       tx_end;
  logic [4:0] power_level;
  logic [7:0] pa_ctrl_word;
  logic       pa_enable;
  logic       tx_ready;
  logic       ramp_busy;
  logic       start_err;
  logic [1:0] state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tx_pa_ramp_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .tx_start     (tx_start),
    .tx_end       (tx_end),
    .power_level  (power_level),
    .pa_ctrl_word (pa_ctrl_word),
    .pa_enable    (pa_enable),
    .tx_ready     (tx_ready),
    .ramp_busy    (ramp_busy),
    .start_err    (start_err),
    .state_dbg    (state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int word, input int en,
                            input int rdy, input int busy, input int st);
    check({tag, ".word"},  32'(pa_ctrl_word), word);
    check({tag, ".en"},    32'(pa_enable),    en);
    check({tag, ".ready"}, 32'(tx_ready),     rdy);
    check({tag, ".busy"},  32'(ramp_busy),    busy);
    check({tag, ".state"}, 32'(state_dbg),    st);
  endtask

  // Inputs change on the falling edge; outputs are sampled on the falling edge.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start(input int level);
    power_level = 5'(level);
    tx_start    = 1'b1;
    cycle();
    tx_start    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tx_start = 1'b0; tx_end = 1'b0; power_level = '0;
    @(negedge clk);
    cycle();
    cycle();
    check_outs("reset", 0, 0, 0, 0, 0);
    check("reset.err", 32'(start_err), 0);

    // Start under reset, then in the release cycle: both ignored.
    tx_start = 1'b1; power_level = 5'd16;
    cycle();
    check("start_in_rst.state", 32'(state_dbg), 0);
    rst = 1'b0;
    cycle();
    tx_start = 1'b0;
    check("start_at_release.state", 32'(state_dbg), 0);
    check("start_at_release.err", 32'(start_err), 0);

    // Scenario 1: full ramp up at level 16.
    start(16);
    check_outs("s1.c0", 0, 1, 0, 1, 1);
    for (int c = 1; c <= 32; c++) begin
      cycle();
      check($sformatf("s1.word.c%0d", c), 32'(pa_ctrl_word), 30 * (c / 4));
      if (c == 31) check("s1.c31.ready", 32'(tx_ready), 0);
    end
    check_outs("s1.hold", 240, 1, 1, 0, 2);
    power_level = 5'd3;
    repeat (4) cycle();
    check("s1.hold_lvl_change", 32'(pa_ctrl_word), 240);

    // Scenario 2 + 5: ramp down; tx_start and tx_end mid-ramp-down.
    tx_end = 1'b1;
    cycle();
    tx_end = 1'b0;
    check_outs("s2.c0", 240, 1, 0, 1, 3);
    for (int c = 1; c <= 32; c++) begin
      tx_start = (c == 10);
      tx_end   = (c == 20);
      cycle();
      tx_start = 1'b0;
      tx_end   = 1'b0;
      check($sformatf("s2.word.c%0d", c), 32'(pa_ctrl_word), 30 * (8 - c / 4));
      if (c == 10) check("s5.err_pulse", 32'(start_err), 1);
      if (c == 11) check("s5.err_clear", 32'(start_err), 0);
      if (c == 31) check("s2.c31.en", 32'(pa_enable), 1);
    end
    check_outs("s2.idle", 0, 0, 0, 0, 0);

    // tx_start with tx_end in IDLE: no change, no error.
    tx_start = 1'b1; tx_end = 1'b1;
    cycle();
    tx_start = 1'b0; tx_end = 1'b0;
    check("s5.both.state", 32'(state_dbg), 0);
    check("s5.both.err", 32'(start_err), 0);
    cycle();
    check("s5.both.state2", 32'(state_dbg), 0);

    // Scenario 3: abort ramp-up at ramp_idx 3.
    start(16);
    repeat (13) cycle();
    check("s3.pre_word", 32'(pa_ctrl_word), 90);
    tx_end = 1'b1;
    cycle();
    tx_end = 1'b0;
    check_outs("s3.d0", 90, 1, 0, 1, 3);
    for (int d = 1; d <= 12; d++) begin
      cycle();
      check($sformatf("s3.word.d%0d", d), 32'(pa_ctrl_word), 30 * (3 - d / 4));
      if (d == 11) check("s3.d11.state", 32'(state_dbg), 3);
    end
    check_outs("s3.idle", 0, 0, 0, 0, 0);

    // Ramp-down entered with ramp_idx 0 exits on the next cycle.
    start(16);
    tx_end = 1'b1;
    cycle();
    tx_end = 1'b0;
    check("idx0.down.state", 32'(state_dbg), 3);
    check("idx0.down.word", 32'(pa_ctrl_word), 0);
    cycle();
    check("idx0.idle.state", 32'(state_dbg), 0);

    // Scenario 4: level 20 clamps to 240; HOLD ignores level and start.
    start(20);
    repeat (32) cycle();
    check_outs("s4.hold", 240, 1, 1, 0, 2);
    power_level = 5'd1;
    repeat (5) cycle();
    check("s4.lvl_change", 32'(pa_ctrl_word), 240);
    tx_start = 1'b1;
    cycle();
    tx_start = 1'b0;
    check("s4.err_pulse", 32'(start_err), 1);
    check("s4.still_hold", 32'(state_dbg), 2);
    cycle();
    check("s4.err_clear", 32'(start_err), 0);
    tx_end = 1'b1;
    cycle();
    tx_end = 1'b0;
    repeat (32) cycle();
    check("s4.idle", 32'(state_dbg), 0);

    // Scenario 6: reset mid ramp-up, then a normal level-8 ramp.
    start(16);
    repeat (20) cycle();
    check("s6.pre_word", 32'(pa_ctrl_word), 150);
    rst = 1'b1;
    cycle();
    check_outs("s6.rst", 0, 0, 0, 0, 0);
    check("s6.rst.err", 32'(start_err), 0);
    rst = 1'b0;
    cycle();
    start(8);
    check("s6.c0.state", 32'(state_dbg), 1);
    for (int c = 1; c <= 32; c++) begin
      cycle();
      check($sformatf("s6.word.c%0d", c), 32'(pa_ctrl_word), 15 * (c / 4));
      if (c == 31) check("s6.c31.ready", 32'(tx_ready), 0);
    end
    check_outs("s6.hold", 120, 1, 1, 0, 2);

    // Reset from HOLD.
    rst = 1'b1;
    cycle();
    check_outs("hold_rst", 0, 0, 0, 0, 0);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_pa_ramp_ctrl.md
TX_PA_RAMP_CTRL -- requirements
Module: tx_pa_ramp_ctrl

Interface
REQ-001 Parameter CONTROL_WORD_WIDTH, default 8: width of the PA control word.
REQ-002 Parameter NUM_POWER_LEVELS, default 17: number of selectable TX power levels, 0..16.
REQ-003 Parameter RAMP_SHIFT, default 3: ramp has RAMP_STEPS = 2^RAMP_SHIFT steps.
REQ-004 Parameter STEP_CYCLES, default 4: clock cycles per ramp step; legal range is at least 1.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset; the ports are named as follows.
REQ-006 clk  in  1  system clock; all state changes on the rising edge.
REQ-007 rst  in  1  synchronous reset, active-high.
REQ-008 tx_start  in  1  single-cycle request to begin a transmission.
REQ-009 tx_end  in  1  single-cycle pulse marking the last modulated sample sent.
REQ-010 power_level  in  5  requested TX power level, sampled only when tx_start is accepted.
REQ-011 pa_ctrl_word  out  CONTROL_WORD_WIDTH  PA drive word.
REQ-012 pa_enable  out  1  PA bias enable.
REQ-013 tx_ready  out  1  power has settled and the modulator may emit samples.
REQ-014 ramp_busy  out  1  a ramp-up or ramp-down is in progress.
REQ-015 start_err  out  1  one-cycle pulse: tx_start was rejected.
REQ-016 state_dbg  out  2  current FSM state encoding, for debug.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE=0, RAMP_UP=1, HOLD=2, RAMP_DOWN=3.
REQ-018 In IDLE, tx_start with tx_end low SHALL move the FSM to RAMP_UP, latch the target word, and clear ramp_idx and the step counter.
REQ-019 Target word = POWER_LUT[min(power_level, NUM_POWER_LEVELS-1)]; POWER_LUT[k] = 15*k, so level 16 gives 240.
REQ-020 In IDLE, tx_start and tx_end asserted in the same cycle SHALL be ignored: the FSM stays in IDLE and start_err stays low.
REQ-021 In RAMP_UP, the step counter SHALL count 0..STEP_CYCLES-1 and, on reaching STEP_CYCLES-1, wrap to 0 and increment ramp_idx.
REQ-022 When ramp_idx reaches RAMP_STEPS, the FSM SHALL enter HOLD, exactly RAMP_STEPS*STEP_CYCLES cycles after acceptance (32 at defaults).
REQ-023 pa_ctrl_word SHALL equal (target*ramp_idx)>>RAMP_SHIFT, computed from registers only, with an intermediate width of CONTROL_WORD_WIDTH+RAMP_SHIFT+1 bits and no overflow.
REQ-024 tx_ready SHALL be high only in HOLD.
REQ-025 In HOLD, power_level changes SHALL be ignored.
REQ-026 tx_end in HOLD SHALL move the FSM to RAMP_DOWN with the step counter cleared.
REQ-027 tx_end in RAMP_UP SHALL move the FSM to RAMP_DOWN starting from the current ramp_idx, with no jump in pa_ctrl_word.
REQ-028 RAMP_DOWN SHALL decrement ramp_idx every STEP_CYCLES cycles and enter IDLE on the cycle ramp_idx reaches 0.
REQ-029 If RAMP_DOWN is entered with ramp_idx=0, the FSM SHALL go to IDLE on the next cycle.
REQ-030 tx_start in any state other than IDLE SHALL be dropped and SHALL pulse start_err for one cycle.
REQ-031 tx_end in IDLE or RAMP_DOWN SHALL be ignored.
REQ-032 pa_enable SHALL be high in every state except IDLE.
REQ-033 ramp_busy SHALL be high in RAMP_UP and RAMP_DOWN only.

Reset
REQ-034 rst SHALL force IDLE, ramp_idx=0, step counter=0 and target=0 at the next edge, including mid-ramp and in HOLD.
REQ-035 Output values under reset SHALL be: pa_ctrl_word=0, pa_enable=0, tx_ready=0, ramp_busy=0, start_err=0, state_dbg=0.
REQ-036 tx_start asserted in the cycle rst is released SHALL be ignored.

Structure
REQ-037 A shared package, tx_pkg, SHALL hold the state enumeration, POWER_LUT and the LUT index clamp function.
REQ-038 The ramp step timing (step counter plus ramp_idx up/down counter) SHALL be one sub-module, ramp_step_counter; all other logic is inline.

Verification
REQ-039 Scenario 1: power_level=16, tx_start -> pa_ctrl_word steps 0,30,60,...,240 every 4 cycles; tx_ready rises 32 cycles after acceptance.
REQ-040 Scenario 2: from HOLD, tx_end -> pa_ctrl_word steps 240 down to 0 over 32 cycles; pa_enable falls when IDLE is entered.
REQ-041 Scenario 3: tx_end while ramp_idx=3 in RAMP_UP (level 16, word 90) -> word goes 90,60,30,0; IDLE reached 12 cycles later.
REQ-042 Scenario 4: power_level=20 -> target clamped to 240; a power_level change during HOLD leaves the word unchanged.
REQ-043 Scenario 5: tx_start during RAMP_DOWN -> start_err pulses once and the ramp continues unaffected; tx_start+tx_end together in IDLE -> no state change.
REQ-044 Scenario 6: rst asserted at ramp_idx=5 of RAMP_UP -> all outputs 0 at the next edge; a new tx_start after reset gives a normal 32-cycle ramp.
